// File: rtl/timer_pkg.sv
// Shared definitions for the general-purpose timer: config select codes,
// CTRL bit positions and the run/idle state encoding.
package timer_pkg;

    localparam int TIM_W = 16;

    localparam int CEN_B = 0;
    localparam int OPM_B = 1;
    localparam int UIE_B = 2;

    typedef enum logic [1:0] {
        SEL_NONE = 2'b00,
        SEL_PSC  = 2'b01,
        SEL_ARR  = 2'b10,
        SEL_CTRL = 2'b11
    } cfg_sel_e;

    // The state is the CEN bit itself.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } tim_state_e;

endpackage

// File: rtl/timer_prescaler.sv
// Prescale counter: counts clocks while enabled and emits a tick every
// (psc_act+1) enabled clocks. The count freezes while disabled.
module timer_prescaler
    import timer_pkg::*;
#(
    parameter int WIDTH = TIM_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] psc_act,
    output logic             tick
);

    logic [WIDTH-1:0] psc_cnt;

    // >= rather than == so a frozen count above a newly loaded PSC cannot run away.
    assign tick = en && (psc_cnt >= psc_act);

    always_ff @(posedge clk) begin
        if (reset) begin
            psc_cnt <= '0;
        end else if (en) begin
            if (tick) begin
                psc_cnt <= '0;
            end else begin
                psc_cnt <= psc_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/gp_timer_core.sv
// Up-counting timer with preload/active PSC and ARR, a control register,
// a sticky update flag and a registered interrupt.
module gp_timer_core
    import timer_pkg::*;
#(
    parameter int               WIDTH   = TIM_W,
    parameter logic [WIDTH-1:0] PSC_RST = '0,
    parameter logic [WIDTH-1:0] ARR_RST = '1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_sel,
    input  logic [WIDTH-1:0] cfg_wdata,
    input  logic             flag_clr,
    output logic [WIDTH-1:0] tim_cnt,
    output logic [2:0]       ctrl_q,
    output logic             upd_pulse,
    output logic             uif,
    output logic             irq
);

    cfg_sel_e         sel;
    tim_state_e       state_q;
    tim_state_e       state_d;
    logic             opm_q;
    logic             uie_q;
    logic [WIDTH-1:0] psc_pre;
    logic [WIDTH-1:0] arr_pre;
    logic [WIDTH-1:0] psc_act;
    logic [WIDTH-1:0] arr_act;
    logic             running;
    logic             tick;
    logic             upd;
    logic             wr_psc;
    logic             wr_arr;
    logic             wr_ctrl;

    assign sel     = cfg_sel_e'(cfg_sel);
    assign wr_psc  = cfg_we && (sel == SEL_PSC);
    assign wr_arr  = cfg_we && (sel == SEL_ARR);
    assign wr_ctrl = cfg_we && (sel == SEL_CTRL);
    assign running = (state_q == ST_RUN);
    assign upd     = tick && (tim_cnt >= arr_act);
    assign ctrl_q  = {uie_q, opm_q, running};

    timer_prescaler #(.WIDTH(WIDTH)) u_prescaler (
        .clk     (clk),
        .reset   (reset),
        .en      (running),
        .psc_act (psc_act),
        .tick    (tick)
    );

    // A CTRL write in the same cycle as a one-pulse auto-stop overrides the stop.
    always_comb begin
        state_d = state_q;
        if (wr_ctrl) begin
            state_d = tim_state_e'(cfg_wdata[CEN_B]);
        end else if (upd && opm_q) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            opm_q     <= 1'b0;
            uie_q     <= 1'b0;
            psc_pre   <= PSC_RST;
            arr_pre   <= ARR_RST;
            psc_act   <= PSC_RST;
            arr_act   <= ARR_RST;
            tim_cnt   <= '0;
            upd_pulse <= 1'b0;
            uif       <= 1'b0;
            irq       <= 1'b0;
        end else begin
            if (wr_psc) psc_pre <= cfg_wdata;
            if (wr_arr) arr_pre <= cfg_wdata;
            if (wr_ctrl) begin
                opm_q <= cfg_wdata[OPM_B];
                uie_q <= cfg_wdata[UIE_B];
            end
            // Active copies take the preload value as it stood before this edge.
            if (!running || upd) begin
                psc_act <= psc_pre;
                arr_act <= arr_pre;
            end
            if (tick) begin
                tim_cnt <= upd ? '0 : tim_cnt + 1'b1;
            end
            upd_pulse <= upd;
            if (upd) begin
                uif <= 1'b1;
            end else if (flag_clr) begin
                uif <= 1'b0;
            end
            irq <= uif & uie_q;
        end
    end

endmodule
